// File: rtl/bcd_display_scan.sv
// Multiplexed 8-digit common-anode seven-segment driver for BCD digits.
// Latches digits on load, blanks leading zeros, and inserts a dark guard cycle per slot.
module bcd_display_scan #(
  parameter int CLK_DIV  = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] ten_0,
  input  logic [3:0] ten_1,
  input  logic [3:0] ten_2,
  input  logic [3:0] ten_3,
  input  logic [3:0] ten_4,
  input  logic [3:0] ten_5,
  input  logic [3:0] ten_6,
  input  logic [3:0] ten_7,
  output logic [6:0] seg_n,
  output logic [7:0] an_n,
  output logic       frame_done
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

  logic [3:0]    shadow [8];
  logic [2:0]    idx;
  logic [PW-1:0] presc;

  logic          term;
  logic          capture;
  logic [3:0]    cur_digit;
  logic [7:0]    zero;
  logic [7:0]    lead;
  logic          blank_cur;

  // Active-low {g,f,e,d,c,b,a}; non-BCD codes show a dash.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h3F;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) shadow[i] <= 4'd0;
    end else if (load) begin
      shadow[0] <= ten_0;
      shadow[1] <= ten_1;
      shadow[2] <= ten_2;
      shadow[3] <= ten_3;
      shadow[4] <= ten_4;
      shadow[5] <= ten_5;
      shadow[6] <= ten_6;
      shadow[7] <= ten_7;
    end
  end

  // lead[k] is set when digits 7..k are all zero; a dash code counts as non-zero.
  always_comb begin
    term      = (presc == LAST);
    capture   = (presc == '0);
    cur_digit = shadow[idx];
    zero      = '0;
    lead      = '0;
    for (int k = 0; k < 8; k++) zero[k] = (shadow[k] == 4'd0);
    lead[7] = zero[7];
    for (int k = 6; k >= 0; k--) lead[k] = lead[k+1] & zero[k];
    blank_cur = BLANK_LZ && (idx != 3'd0) && lead[idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= 3'd0;
    end else if (term) begin
      presc <= '0;
      idx   <= idx + 3'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Outputs are registered from the upcoming prescaler state so the guard cycle is dark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n       <= 8'hFF;
      seg_n      <= 7'h7F;
      frame_done <= 1'b0;
    end else if (term) begin
      an_n       <= 8'hFF;
      seg_n      <= 7'h7F;
      frame_done <= (idx == 3'd7);
    end else if (capture) begin
      frame_done <= 1'b0;
      if (blank_cur) begin
        an_n  <= 8'hFF;
        seg_n <= 7'h7F;
      end else begin
        an_n  <= ~(8'd1 << idx);
        seg_n <= seg7(cur_digit);
      end
    end else begin
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Slot-by-slot scoreboard bench for bcd_display_scan with CLK_DIV=4,
// running blanking-enabled and blanking-disabled instances side by side.
module tb_bcd_display_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic [3:0] d_in [8];
  logic [6:0] seg_n, seg_n_nb;
  logic [7:0] an_n, an_n_nb;
  logic       frame_done, frame_done_nb;

  typedef struct {
    logic [7:0] an1;
    logic [6:0] seg1;
    logic [7:0] an0;
    logic [6:0] seg0;
  } exp_t;

  exp_t       sb [$];
  logic [3:0] d_model [8];
  int         cur_idx;
  bit         first_slot;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  bcd_display_scan #(.CLK_DIV(4), .BLANK_LZ(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .load(load),
    .ten_0(d_in[0]), .ten_1(d_in[1]), .ten_2(d_in[2]), .ten_3(d_in[3]),
    .ten_4(d_in[4]), .ten_5(d_in[5]), .ten_6(d_in[6]), .ten_7(d_in[7]),
    .seg_n(seg_n), .an_n(an_n), .frame_done(frame_done)
  );

  bcd_display_scan #(.CLK_DIV(4), .BLANK_LZ(1'b0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .load(load),
    .ten_0(d_in[0]), .ten_1(d_in[1]), .ten_2(d_in[2]), .ten_3(d_in[3]),
    .ten_4(d_in[4]), .ten_5(d_in[5]), .ten_6(d_in[6]), .ten_7(d_in[7]),
    .seg_n(seg_n_nb), .an_n(an_n_nb), .frame_done(frame_done_nb)
  );

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    return tbl[d];
  endfunction

  function automatic bit ref_blank(input int k);
    if (k == 0) return 1'b0;
    for (int j = k; j < 8; j++)
      if (d_model[j] != 4'd0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s slot=%0d observed=%h expected=%h", tag, cur_idx, obs, exp);
    end
  endtask

  task automatic checkReset();
    checkOutput("rst_an", an_n, 8'hFF);
    checkOutput("rst_seg", {1'b0, seg_n}, 8'h7F);
    checkOutput("rst_fd", {7'd0, frame_done}, 8'h00);
    checkOutput("rst_an_nb", an_n_nb, 8'hFF);
  endtask

  task automatic applyStimulus(input logic [31:0] digits);
    for (int i = 0; i < 8; i++) d_in[i] = digits[i*4 +: 4];
  endtask

  // ld_mode: 0 none, 1 load on the capture edge, 2 load at prescaler=2.
  // rst_after: nonzero asserts reset after that many active samples.
  task automatic doSlot(input int ld_mode, input int rst_after);
    exp_t e;
    e.an1  = ref_blank(cur_idx) ? 8'hFF : ~(8'd1 << cur_idx);
    e.seg1 = ref_blank(cur_idx) ? 7'h7F : ref_seg(d_model[cur_idx]);
    e.an0  = ~(8'd1 << cur_idx);
    e.seg0 = ref_seg(d_model[cur_idx]);
    sb.push_back(e);
    e = sb.pop_front();

    checkOutput("guard_an", an_n, 8'hFF);
    checkOutput("guard_seg", {1'b0, seg_n}, 8'h7F);
    checkOutput("guard_fd", {7'd0, frame_done},
                {7'd0, (cur_idx == 0 && !first_slot)});
    checkOutput("guard_an_nb", an_n_nb, 8'hFF);
    if (ld_mode == 1) load = 1'b1;

    for (int a = 1; a <= 3; a++) begin
      @(negedge clk);
      if (load) begin
        load = 1'b0;
        for (int i = 0; i < 8; i++) d_model[i] = d_in[i];
      end
      checkOutput("act_an", an_n, e.an1);
      checkOutput("act_seg", {1'b0, seg_n}, {1'b0, e.seg1});
      checkOutput("act_fd", {7'd0, frame_done}, 8'h00);
      checkOutput("act_an_nb", an_n_nb, e.an0);
      checkOutput("act_seg_nb", {1'b0, seg_n_nb}, {1'b0, e.seg0});
      if (a == rst_after) begin
        #2 rst_n = 1'b0;
        #1 checkReset();
        for (int i = 0; i < 8; i++) d_model[i] = 4'd0;
        repeat (3) @(negedge clk);
        checkReset();
        rst_n      = 1'b1;
        cur_idx    = 0;
        first_slot = 1'b1;
        return;
      end
      if (a == 2 && ld_mode == 2) load = 1'b1;
    end

    @(negedge clk);
    if (load) begin
      load = 1'b0;
      for (int i = 0; i < 8; i++) d_model[i] = d_in[i];
    end
    cur_idx    = (cur_idx + 1) % 8;
    first_slot = 1'b0;
  endtask

  task automatic doFrame(input bit load_next);
    for (int s = 0; s < 8; s++) doSlot((s == 7 && load_next) ? 2 : 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    load  = 1'b0;
    applyStimulus(32'h0);
    for (int i = 0; i < 8; i++) d_model[i] = 4'd0;
    cur_idx    = 0;
    first_slot = 1'b1;
    repeat (3) @(negedge clk);
    checkReset();
    rst_n = 1'b1;

    applyStimulus(32'h12345678);
    doFrame(1'b1);
    applyStimulus(32'h00000042);
    doFrame(1'b1);
    applyStimulus(32'h00100500);
    doFrame(1'b1);
    applyStimulus(32'h0000C000);
    doFrame(1'b1);
    applyStimulus(32'h11111111);
    doFrame(1'b1);
    doFrame(1'b0);

    applyStimulus(32'h22222222);
    for (int s = 0; s < 8; s++) doSlot((s == 2) ? 1 : 0, 0);

    applyStimulus(32'h33333333);
    for (int s = 0; s < 8; s++) doSlot((s == 3) ? 2 : 0, 0);

    for (int s = 0; s < 5; s++) doSlot(0, 0);
    doSlot(0, 2);

    doFrame(1'b0);
    doSlot(0, 0);

    if (sb.size() != 0) begin
      errors++;
      $error("[TB] FAIL scoreboard_leftover count=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout");
    $fatal(1, "[TB] timeout");
  end

endmodule
